// File: rtl/input_link_router_mc.sv
// Input link router: assembles a HEADER_WORDS header, then routes payload to a local subunit or the transmit link.
// Optional trailer checksum is enabled by defining ILR_CHECKSUM_EN.
module input_link_router_mc #(
  parameter int LINK_NUMBER      = 0,
  parameter int DATA_WIDTH       = 32,
  parameter int SUBUNIT_QUANTITY = 4,
  parameter int HEADER_WORDS     = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  input  logic [DATA_WIDTH-1:0]              in_data,
  output logic                               in_ready,
  output logic [HEADER_WORDS*DATA_WIDTH-1:0] header_out,
  output logic                               header_valid,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic [SUBUNIT_QUANTITY-1:0]        sub_valid,
  input  logic [SUBUNIT_QUANTITY-1:0]        hardware_subunit_input_buffer_full,
  output logic                               tx_valid,
  input  logic                               transmit_link_output_buffer_full,
  input  logic                               op_complete,
  output logic                               ready,
  output logic                               route_err
);

  // state     | meaning
  // S_IDLE    | waiting for header word0
  // S_HDR     | collecting header words 1..HEADER_WORDS-1
  // S_LOCAL   | streaming payload to the selected subunit
  // S_CHK     | consuming the trailer of a local packet (checksum build)
  // S_WAIT_OP | payload delivered, holding until op_complete
  // S_FWD_HDR | replaying the stored header to the transmit link
  // S_FWD_PAY | streaming payload (and trailer) to the transmit link
  // S_DROP    | discarding payload of a packet for a bad subunit

`ifdef ILR_CHECKSUM_EN
  localparam int TRL = 1;
`else
  localparam int TRL = 0;
`endif
  localparam int CW   = 16 + TRL;
  localparam int HW_W = (HEADER_WORDS > 1) ? $clog2(HEADER_WORDS) : 1;
  localparam logic [HW_W-1:0] LAST = HW_W'(HEADER_WORDS - 1);
  localparam bit SINGLE = (HEADER_WORDS == 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_LOCAL, S_CHK, S_WAIT_OP, S_FWD_HDR, S_FWD_PAY, S_DROP
  } state_t;

  state_t                                   state;
  logic [HEADER_WORDS-1:0][DATA_WIDTH-1:0]  hdr_q;
  logic [HW_W-1:0]                          idx_q;
  logic [CW-1:0]                            rem_q;
  logic [3:0]                               sub_q;
  logic                                     err_q;
  logic                                     xfer;
  logic                                     full_sel;
  logic                                     hdr_done;
  logic                                     chk_bad;
  logic [31:0]                              w0;
  logic                                     w0_local;
  logic                                     w0_id_ok;
  logic [CW-1:0]                            len_eff;
  logic                                     unused_w0;

  // word0 comes straight off the link when the header is a single word
  assign w0        = (state == S_IDLE) ? in_data[31:0] : hdr_q[0][31:0];
  assign w0_local  = (w0[7:0] == 8'(LINK_NUMBER));
  assign w0_id_ok  = ({28'd0, w0[11:8]} < 32'(SUBUNIT_QUANTITY));
  assign len_eff   = CW'(w0[31:16]) + CW'(TRL);
  assign unused_w0 = ^w0[15:12];

  assign header_out   = hdr_q;
  assign ready        = (state == S_IDLE);
  assign header_valid = (state == S_LOCAL) || (state == S_CHK) || (state == S_WAIT_OP);

  always_comb begin
    full_sel = 1'b0;
    for (int i = 0; i < SUBUNIT_QUANTITY; i++)
      if (sub_q == 4'(i)) full_sel = hardware_subunit_input_buffer_full[i];
  end

  always_comb begin
    case (state)
      S_IDLE, S_HDR, S_CHK, S_DROP: in_ready = 1'b1;
      S_LOCAL:                      in_ready = ~full_sel;
      S_FWD_PAY:                    in_ready = ~transmit_link_output_buffer_full;
      default:                      in_ready = 1'b0;
    endcase
    if (!rst_n) in_ready = 1'b0;
  end

  assign xfer     = in_valid && in_ready;
  assign hdr_done = xfer && ((SINGLE && state == S_IDLE) || (state == S_HDR && idx_q == LAST));

  always_comb begin
    out_data  = '0;
    sub_valid = '0;
    tx_valid  = 1'b0;
    case (state)
      S_LOCAL: begin
        out_data = in_data;
        for (int i = 0; i < SUBUNIT_QUANTITY; i++)
          sub_valid[i] = xfer && (sub_q == 4'(i));
      end
      S_FWD_HDR: begin
        out_data = hdr_q[idx_q];
        tx_valid = ~transmit_link_output_buffer_full;
      end
      S_FWD_PAY: begin
        out_data = in_data;
        tx_valid = xfer;
      end
      default: ;
    endcase
  end

`ifdef ILR_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else if (xfer) begin
      if (state == S_IDLE) csum_q <= in_data;
      else if (state == S_HDR || state == S_LOCAL) csum_q <= csum_q ^ in_data;
    end
  end

  assign chk_bad   = (state == S_CHK) && xfer && (csum_q != in_data);
  assign route_err = err_q | chk_bad;
`else
  assign chk_bad   = 1'b0;
  assign route_err = err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      hdr_q <= '0;
      idx_q <= '0;
      rem_q <= '0;
      sub_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        S_IDLE: if (xfer) begin
          hdr_q[0] <= in_data;
          idx_q    <= HW_W'(1);
          state    <= S_HDR;
        end
        S_HDR: if (xfer) begin
          hdr_q[idx_q] <= in_data;
          idx_q        <= idx_q + 1'b1;
        end
        S_LOCAL: if (xfer) begin
          rem_q <= rem_q - 1'b1;
          if (rem_q == CW'(1)) state <= (TRL != 0) ? S_CHK : S_WAIT_OP;
        end
        S_CHK: if (xfer) state <= chk_bad ? S_IDLE : S_WAIT_OP;
        S_WAIT_OP: if (op_complete) state <= S_IDLE;
        S_FWD_HDR: if (!transmit_link_output_buffer_full) begin
          if (idx_q == LAST) state <= (rem_q == '0) ? S_IDLE : S_FWD_PAY;
          else idx_q <= idx_q + 1'b1;
        end
        S_FWD_PAY, S_DROP: if (xfer) begin
          rem_q <= rem_q - 1'b1;
          if (rem_q == CW'(1)) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // routing decision overrides the header-collection transition above
      if (hdr_done) begin
        sub_q <= w0[11:8];
        rem_q <= len_eff;
        idx_q <= '0;
        if (!w0_local) begin
          state <= S_FWD_HDR;
        end else if (!w0_id_ok) begin
          err_q <= 1'b1;
          state <= (len_eff == '0) ? S_IDLE : S_DROP;
        end else if (w0[31:16] != 16'd0) begin
          rem_q <= CW'(w0[31:16]);
          state <= S_LOCAL;
        end else begin
          state <= (TRL != 0) ? S_CHK : S_WAIT_OP;
        end
      end
    end
  end

endmodule

// File: tb/tb_input_link_router_mc.sv
// Self-checking bench for input_link_router_mc: directed cases plus randomized packets
// scored against a queue-based packet model.
module tb_input_link_router_mc;
  localparam int SQ = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [31:0]  in_data;
  logic         in_ready;
  logic [127:0] header_out;
  logic         header_valid;
  logic [31:0]  out_data;
  logic [3:0]   sub_valid;
  logic [3:0]   sub_full;
  logic         tx_valid;
  logic         tx_full;
  logic         op_complete;
  logic         ready;
  logic         route_err;

  always #5 clk = ~clk;

  input_link_router_mc #(
    .LINK_NUMBER(0), .DATA_WIDTH(32), .SUBUNIT_QUANTITY(SQ), .HEADER_WORDS(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .header_out(header_out), .header_valid(header_valid), .out_data(out_data),
    .sub_valid(sub_valid), .hardware_subunit_input_buffer_full(sub_full),
    .tx_valid(tx_valid), .transmit_link_output_buffer_full(tx_full),
    .op_complete(op_complete), .ready(ready), .route_err(route_err)
  );

  int           checks = 0;
  int           errors = 0;
  bit           rand_en = 1'b0;
  logic [35:0]  exp_sub[$];
  logic [35:0]  got_sub[$];
  logic [31:0]  exp_tx[$];
  logic [31:0]  got_tx[$];
  int           exp_err = 0;
  int           err_seen = 0;
  logic [127:0] exp_hdr;
  logic [127:0] last_hdr;
  bit           prev_err = 1'b0;
  int           mon_id;
  logic [35:0]  mon_e;
  logic [31:0]  mon_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // packet model: decides destination purely from word0 fields
  function automatic int model_packet(input logic [31:0] w[$]);
    logic [7:0] dest = w[0][7:0];
    logic [3:0] id   = w[0][11:8];
    int         len  = int'(w[0][31:16]);
    exp_hdr = {w[3], w[2], w[1], w[0]};
    if (dest != 8'd0) begin
      foreach (w[k]) exp_tx.push_back(w[k]);
      return 2;
    end
    if (int'(id) >= SQ) begin
      exp_err++;
      return 1;
    end
    for (int k = 0; k < len; k++) exp_sub.push_back({id, w[4+k]});
    return 0;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (sub_valid != 4'd0) begin
        mon_id = 0;
        for (int k = 0; k < SQ; k++) if (sub_valid[k]) mon_id = k;
        check("sub_onehot", $onehot(sub_valid), 1);
        check("sub_tx_exclusive", tx_valid, 0);
        check("sub_not_full", sub_valid & sub_full, 0);
        check("sub_header_valid", header_valid, 1);
        got_sub.push_back({4'(mon_id), out_data});
        check("sub_expected_pending", exp_sub.size() != 0, 1);
        if (exp_sub.size() != 0) begin
          mon_e = exp_sub.pop_front();
          check("sub_word", {4'(mon_id), out_data}, mon_e);
        end
      end
      if (tx_valid) begin
        check("tx_not_full", tx_full, 0);
        got_tx.push_back(out_data);
        check("tx_expected_pending", exp_tx.size() != 0, 1);
        if (exp_tx.size() != 0) begin
          mon_t = exp_tx.pop_front();
          check("tx_word", out_data, mon_t);
        end
      end
      if (route_err) begin
        check("route_err_one_cycle", prev_err, 0);
        err_seen++;
      end
    end
    prev_err = route_err;
  end

  task automatic drive_flags();
    if (rand_en) begin
      sub_full = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      tx_full  = ($urandom_range(0, 3) == 0);
    end else begin
      sub_full = 4'd0;
      tx_full  = 1'b0;
    end
  endtask

  // called and returns at posedge+1
  task automatic send_words(input logic [31:0] w[$]);
    int i = 0;
    int guard = 0;
    bit took;
    while (i < w.size() && guard < 1000) begin
      in_valid    = rand_en ? ($urandom_range(0, 4) != 0) : 1'b1;
      in_data     = w[i];
      drive_flags();
      op_complete = rand_en && ($urandom_range(0, 7) == 0);
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk); #1;
      if (took) i++;
      guard++;
    end
    in_valid    = 1'b0;
    in_data     = 32'd0;
    op_complete = 1'b0;
    check("send_complete", i, w.size());
  endtask

  task automatic wait_ready(input int budget);
    int c = 0;
    @(negedge clk);
    while (!ready && c < budget) begin
      @(posedge clk); #1;
      drive_flags();
      @(negedge clk);
      c++;
    end
    check("ready_returns", ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic finish_local(input logic [127:0] hdr);
    @(negedge clk);
    last_hdr = header_out;
    check("wait_ready_low", ready, 0);
    check("wait_header_valid", header_valid, 1);
    check("wait_in_ready_low", in_ready, 0);
    check("wait_header_out", header_out, hdr);
    repeat ($urandom_range(0, 3)) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("hold_ready_low", ready, 0);
    end
    @(posedge clk); #1;
    op_complete = 1'b1;
    @(posedge clk); #1;
    op_complete = 1'b0;
    @(negedge clk);
    check("op_done_ready", ready, 1);
    check("op_done_header_valid", header_valid, 0);
    @(posedge clk); #1;
  endtask

  task automatic drain_checks();
    check("sub_drained", exp_sub.size(), 0);
    check("tx_drained", exp_tx.size(), 0);
    check("err_count", err_seen, exp_err);
  endtask

  task automatic run_packet(input logic [31:0] w[$]);
    int kind;
    kind = model_packet(w);
    send_words(w);
    if (kind == 0) finish_local(exp_hdr);
    else wait_ready(300);
    drain_checks();
  endtask

  task automatic random_packet();
    logic [31:0] w[$];
    logic [7:0]  dest;
    logic [3:0]  id;
    logic [15:0] len;
    dest = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
    id   = 4'($urandom_range(0, 5));
    len  = 16'($urandom_range(0, 6));
    w.push_back({len, 4'($urandom_range(0, 15)), id, dest});
    repeat (3 + int'(len)) w.push_back($urandom);
    run_packet(w);
  endtask

  task automatic check_reset_values();
    check("rst_in_ready", in_ready, 0);
    check("rst_header_valid", header_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_sub_valid", sub_valid, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_route_err", route_err, 0);
    check("rst_ready", ready, 1);
    check("rst_header_out", header_out, 0);
  endtask

  initial begin
    logic [31:0] w[$];
    logic [31:0] p[$];
    int e0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 32'd0;
    sub_full = 4'd0; tx_full = 1'b0; op_complete = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", ready, 1);
    @(posedge clk); #1;

    // local packet to subunit 2
    got_sub.delete(); got_tx.delete();
    w = {32'h0003_0200, 32'd1, 32'd2, 32'd3, 32'hAA, 32'hBB, 32'hCC};
    run_packet(w);
    check("t1_count", got_sub.size(), 3);
    check("t1_w0", got_sub[0], {4'd2, 32'hAA});
    check("t1_w1", got_sub[1], {4'd2, 32'hBB});
    check("t1_w2", got_sub[2], {4'd2, 32'hCC});
    check("t1_header", last_hdr, {32'd3, 32'd2, 32'd1, 32'h0003_0200});
    check("t1_no_tx", got_tx.size(), 0);

    // forward to link 5
    got_sub.delete(); got_tx.delete();
    w = {32'h0002_0105, 32'd1, 32'd2, 32'd3, 32'h11, 32'h22};
    run_packet(w);
    check("t2_count", got_tx.size(), 6);
    check("t2_seq", {got_tx[0], got_tx[1], got_tx[2], got_tx[3]},
          {32'h0002_0105, 32'd1, 32'd2, 32'd3});
    check("t2_pay", {got_tx[4], got_tx[5]}, {32'h11, 32'h22});
    check("t2_no_sub", got_sub.size(), 0);

    // backpressure on subunit 2 mid-payload
    got_sub.delete(); got_tx.delete();
    w = {32'h0004_0200, 32'd4, 32'd5, 32'd6, 32'hD0, 32'hD1, 32'hD2, 32'hD3};
    void'(model_packet(w));
    p = {32'h0004_0200, 32'd4, 32'd5, 32'd6, 32'hD0, 32'hD1};
    send_words(p);
    in_valid = 1'b1; in_data = 32'hD2; sub_full = 4'b0100;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_sub_valid", sub_valid, 0);
      @(posedge clk); #1;
    end
    sub_full = 4'd0;
    p = {32'hD2, 32'hD3};
    send_words(p);
    finish_local(exp_hdr);
    drain_checks();
    check("t3_count", got_sub.size(), 4);
    check("t3_seq", {got_sub[0], got_sub[1], got_sub[2], got_sub[3]},
          {4'd2, 32'hD0, 4'd2, 32'hD1, 4'd2, 32'hD2, 4'd2, 32'hD3});

    // bad subunit id 5
    got_sub.delete(); got_tx.delete();
    e0 = err_seen;
    w = {32'h0002_0500, 32'd1, 32'd2, 32'd3, 32'h5A, 32'h5B};
    run_packet(w);
    check("t4_err_pulses", err_seen - e0, 1);
    check("t4_no_sub", got_sub.size(), 0);
    check("t4_no_tx", got_tx.size(), 0);

    // zero-length local packet
    got_sub.delete(); got_tx.delete();
    w = {32'h0000_0100, 32'd1, 32'd2, 32'd3};
    run_packet(w);
    check("t5_no_sub", got_sub.size(), 0);
    check("t5_header", last_hdr, {32'd3, 32'd2, 32'd1, 32'h0000_0100});

    // reset in the middle of a local payload
    got_sub.delete(); got_tx.delete();
    w = {32'h0003_0100, 32'd7, 32'd8, 32'd9, 32'hE0, 32'hE1, 32'hE2};
    void'(model_packet(w));
    p = {32'h0003_0100, 32'd7, 32'd8, 32'd9, 32'hE0};
    send_words(p);
    in_valid = 1'b1; in_data = 32'hE1; rst_n = 1'b0;
    @(negedge clk);
    check_reset_values();
    check("t6_before_reset", got_sub.size(), 1);
    exp_sub.delete(); got_sub.delete();
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("t6_ready_release", ready, 1);
    @(posedge clk); #1;
    w = {32'h0002_0300, 32'd4, 32'd5, 32'd6, 32'hF0, 32'hF1};
    run_packet(w);
    check("t6_after_count", got_sub.size(), 2);
    check("t6_after_seq", {got_sub[0], got_sub[1]}, {4'd3, 32'hF0, 4'd3, 32'hF1});

    rand_en = 1'b1;
    for (int n = 0; n < 150; n++) random_packet();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
